mem_rd_skew: RTL and testbench



---
 rtl/tpu_pkg.sv | 18 +
 rtl/skew_lane.sv | 34 +++
 rtl/mem_rd_skew.sv | 74 +++++++
 tb/tb_mem_rd_skew.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared constants and lane-slice helper for the memArr read path
package tpu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ROW_CNT_W  = 16;
    localparam int MAX_LANE_W = 32;
    localparam int MAX_ROW_W  = 32 * MAX_LANE_W;

    // Lane k of a packed row; caller narrows the result to its own lane width.
    function automatic logic [MAX_LANE_W-1:0] lane_slice(
        input logic [MAX_ROW_W-1:0] row,
        input int                   k,
        input int                   lane_w
    );
        return MAX_LANE_W'(row >> (k * lane_w));
    endfunction

endpackage

// File: rtl/skew_lane.sv
// rtl/skew_lane.sv - DEPTH-stage {valid, data} delay chain for one skew lane
module skew_lane #(
    parameter int DEPTH  = 1,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [DEPTH-1:0]  vld;
    logic [DATA_W-1:0] dat [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_valid ? in_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_data  = vld[DEPTH-1] ? dat[DEPTH-1] : '0;

endmodule

// File: rtl/mem_rd_skew.sv
// rtl/mem_rd_skew.sv - diagonal skew of memArr rows into systolic wavefront order; MEM_RD_SKEW_ROW_CNT_EN adds row counter
module mem_rd_skew
    import tpu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [WIDTH*DATA_W-1:0] in_data,
    output logic [WIDTH*DATA_W-1:0] out_data,
    output logic [WIDTH-1:0]        out_valid,
    output logic                    busy,
    output logic                    done
`ifdef MEM_RD_SKEW_ROW_CNT_EN
    ,
    output logic [ROW_CNT_W-1:0]    row_cnt,
    output logic [ROW_CNT_W-1:0]    row_cnt_last
`endif
);

    for (genvar k = 0; k < WIDTH; k++) begin : g_lane
        logic [DATA_W-1:0] lane_in;
        assign lane_in = DATA_W'(lane_slice(MAX_ROW_W'(in_data), k, DATA_W));

        skew_lane #(
            .DEPTH  (k + 1),
            .DATA_W (DATA_W)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (in_valid),
            .in_data   (lane_in),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W])
        );
    end

    // Every lane is fed the same in_valid, so the deepest lane's valid chain
    // holds the union of all stage valid bits; track it here as occupancy.
    logic [WIDTH-1:0] occ;
    logic             busy_next;

    always_ff @(posedge clk) begin
        if (reset) occ <= '0;
        else       occ <= {occ[WIDTH-2:0], in_valid};
    end

    assign busy      = |occ;
    assign busy_next = in_valid | (|occ[WIDTH-2:0]);

    always_ff @(posedge clk) begin
        if (reset) done <= 1'b0;
        else       done <= busy & ~busy_next;
    end

`ifdef MEM_RD_SKEW_ROW_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt      <= '0;
            row_cnt_last <= '0;
        end else if (done) begin
            row_cnt_last <= row_cnt;
            row_cnt      <= '0;
        end else if (out_valid[WIDTH-1] && (row_cnt != '1)) begin
            row_cnt <= row_cnt + 1'b1;
        end
    end
`else
    // row counter not built
`endif

endmodule

// File: tb/tb_mem_rd_skew.sv
// tb/tb_mem_rd_skew.sv - vector-table bench for mem_rd_skew at WIDTH=4, DATA_W=8
module tb_mem_rd_skew;

    localparam int WIDTH  = 4;
    localparam int DATA_W = 8;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic [WIDTH*DATA_W-1:0] in_data;
    logic [WIDTH*DATA_W-1:0] out_data;
    logic [WIDTH-1:0]        out_valid;
    logic                    busy;
    logic                    done;
`ifdef MEM_RD_SKEW_ROW_CNT_EN
    logic [15:0]             row_cnt;
    logic [15:0]             row_cnt_last;
`endif

    always #5 clk = ~clk;

    mem_rd_skew #(
        .WIDTH  (WIDTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
`ifdef MEM_RD_SKEW_ROW_CNT_EN
        ,
        .row_cnt      (row_cnt),
        .row_cnt_last (row_cnt_last)
`endif
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] din;
        logic [31:0] od;
        logic [3:0]  ov;
        logic        bsy;
        logic        dn;
    } vec_t;

    vec_t tv[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic add(input logic r, input logic iv, input logic [31:0] din,
                       input logic [31:0] od, input logic [3:0] ov,
                       input logic bsy, input logic dn);
        vec_t v;
        v.rst = r; v.iv = iv; v.din = din; v.od = od; v.ov = ov; v.bsy = bsy; v.dn = dn;
        tv.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(0, 0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic single_row();
        add(0, 1, 32'h04030201, 32'h0,        4'b0000, 1'bx, 0);
        add(0, 0, 32'h0,        32'h00000001, 4'b0001, 1,    0);
        add(0, 0, 32'h0,        32'h00000200, 4'b0010, 1,    0);
        add(0, 0, 32'h0,        32'h00030000, 4'b0100, 1,    0);
        add(0, 0, 32'h0,        32'h04000000, 4'b1000, 1,    0);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    1);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    0);
    endtask

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step=%0d actual=%h expected=%h", name, t, act, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;

        idle(20);
        single_row();
        // three-row burst
        add(0, 1, 32'h41312111, 32'h0,        4'b0000, 1'bx, 0);
        add(0, 1, 32'h42322212, 32'h00000011, 4'b0001, 1,    0);
        add(0, 1, 32'h43332313, 32'h00002112, 4'b0011, 1,    0);
        add(0, 0, 32'h0,        32'h00312213, 4'b0111, 1,    0);
        add(0, 0, 32'h0,        32'h41322300, 4'b1110, 1,    0);
        add(0, 0, 32'h0,        32'h42330000, 4'b1100, 1,    0);
        add(0, 0, 32'h0,        32'h43000000, 4'b1000, 1,    0);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    1);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    0);
        // valid pattern 1,0,1 with garbage data in the gap
        add(0, 1, 32'hA4A3A2A1, 32'h0,        4'b0000, 1'bx, 0);
        add(0, 0, 32'hDEADBEEF, 32'h000000A1, 4'b0001, 1,    0);
        add(0, 1, 32'hB4B3B2B1, 32'h0000A200, 4'b0010, 1,    0);
        add(0, 0, 32'hDEADBEEF, 32'h00A300B1, 4'b0101, 1,    0);
        add(0, 0, 32'h0,        32'hA400B200, 4'b1010, 1,    0);
        add(0, 0, 32'h0,        32'h00B30000, 4'b0100, 1,    0);
        add(0, 0, 32'h0,        32'hB4000000, 4'b1000, 1,    0);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    1);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    0);
        // new row enters while the previous one is still draining: one done only
        add(0, 1, 32'h0C0B0A09, 32'h0,        4'b0000, 1'bx, 0);
        add(0, 0, 32'h0,        32'h00000009, 4'b0001, 1,    0);
        add(0, 0, 32'h0,        32'h00000A00, 4'b0010, 1,    0);
        add(0, 0, 32'h0,        32'h000B0000, 4'b0100, 1,    0);
        add(0, 1, 32'h1D1C1B1A, 32'h0C000000, 4'b1000, 1,    0);
        add(0, 0, 32'h0,        32'h0000001A, 4'b0001, 1,    0);
        add(0, 0, 32'h0,        32'h00001B00, 4'b0010, 1,    0);
        add(0, 0, 32'h0,        32'h001C0000, 4'b0100, 1,    0);
        add(0, 0, 32'h0,        32'h1D000000, 4'b1000, 1,    0);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    1);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    0);
        // reset in the third cycle of a burst aborts it without done
        add(0, 1, 32'h34241404, 32'h0,        4'b0000, 1'bx, 0);
        add(0, 1, 32'h35251505, 32'h00000004, 4'b0001, 1,    0);
        add(1, 1, 32'h36261606, 32'h00001405, 4'b0011, 1,    0);
        add(0, 0, 32'h0,        32'h0,        4'b0000, 0,    0);
        idle(6);
        single_row();
        idle(2);

        repeat (2) @(posedge clk);
        for (int t = 0; t < tv.size(); t++) begin
            @(posedge clk);
            #1;
            chk("out_data",  t, out_data, tv[t].od);
            chk("out_valid", t, 32'(out_valid), 32'(tv[t].ov));
            chk("done",      t, 32'(done), 32'(tv[t].dn));
            if (tv[t].bsy !== 1'bx) chk("busy", t, 32'(busy), 32'(tv[t].bsy));
            reset    = tv[t].rst;
            in_valid = tv[t].iv;
            in_data  = tv[t].din;
        end

`ifdef MEM_RD_SKEW_ROW_CNT_EN
        begin
            logic [15:0] exp_cnt [12];
            exp_cnt = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3,
                        16'd4, 16'd5, 16'd0, 16'd0};
            for (int c = 0; c < 12; c++) begin
                @(posedge clk);
                #1;
                chk("row_cnt", c, 32'(row_cnt), 32'(exp_cnt[c]));
                if (c == 9)  chk("cnt_done", c, 32'(done), 32'd1);
                if (c >= 10) chk("row_cnt_last", c, 32'(row_cnt_last), 32'd5);
                in_valid = (c < 5);
                in_data  = 32'h01010101 * (c + 1);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
